// File: rtl/alu_mc_if.sv
// alu_mc_if: the valid/ready bus of the multi-cycle ALU.
//   Request side : in_valid, in_ready, op[3:0], a, b, cin
//   Response side: out_valid, out_ready, result, flag_z/n/c/v, op_err
//   master : operand-fetch / writeback side (drives requests, accepts results)
//   slave  : the ALU itself
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             op_err;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, op_err
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, op_err
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : alu_mc_if.slave -- op/operand request with in_valid/in_ready,
//           registered result + flags with out_valid/out_ready
// Single-cycle ops (ADD, ADDC, SUB, OR, NOR, AND, ZERO, undefined) finish on
// the accept edge. Shifts move one bit per cycle for b[SHW-1:0] cycles; MUL is
// a shift-add multiplier taking exactly WIDTH cycles.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic   clk,
  input  logic   reset,
  alu_mc_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_ZERO = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;   // upper product half during MUL
  logic [WIDTH-1:0] lo_q, lo_d;   // shift register / multiplier+lower product
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;

  logic             accept;
  logic             wr;
  logic [WIDTH-1:0] res_w;
  logic             c_w, v_w, err_w;
  logic [WIDTH-1:0] b_eff;
  logic             cy;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   psum;
  logic [WIDTH-1:0] shifted;
  logic             shout;

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.op_err    = err_q;

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    err_d    = err_q;
    wr       = 1'b0;
    res_w    = '0;
    c_w      = 1'b0;
    v_w      = 1'b0;
    err_w    = 1'b0;

    // SUB reuses the adder as a + ~b + 1, so the same overflow test applies to b_eff.
    b_eff = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    cy    = (bus.op == OP_SUB) | ((bus.op == OP_ADDC) & bus.cin);
    sum   = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cy};

    // Shift-add step: conditionally add multiplicand to the upper half, then
    // shift the whole {carry, hi, lo} right by one.
    addend = lo_q[0] ? mcand_q : '0;
    psum   = {1'b0, hi_q} + {1'b0, addend};

    shifted = lo_q;
    shout   = 1'b0;
    case (op_q)
      OP_SLL: begin shifted = {lo_q[WIDTH-2:0], 1'b0};        shout = lo_q[WIDTH-1]; end
      OP_SRL: begin shifted = {1'b0, lo_q[WIDTH-1:1]};        shout = lo_q[0];       end
      OP_SRA: begin shifted = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]}; shout = lo_q[0];     end
      default: ;
    endcase

    if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        hi_d = psum[WIDTH:1];
        lo_d = {psum[0], lo_q[WIDTH-1:1]};
      end else begin
        lo_d = shifted;
      end
      if (cnt_q == CW'(1)) begin
        wr      = 1'b1;
        res_w   = lo_d;
        c_w     = (op_q == OP_MUL) ? (|hi_d) : shout;
        state_d = DONE;
      end
    end else if (accept) begin
      state_d = DONE;
      case (bus.op)
        OP_ADD, OP_ADDC, OP_SUB: begin
          wr    = 1'b1;
          res_w = sum[WIDTH-1:0];
          c_w   = sum[WIDTH];
          v_w   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
        OP_OR:   begin wr = 1'b1; res_w = bus.a | bus.b;    end
        OP_NOR:  begin wr = 1'b1; res_w = ~(bus.a | bus.b); end
        OP_AND:  begin wr = 1'b1; res_w = bus.a & bus.b;    end
        OP_ZERO: begin wr = 1'b1; res_w = '0;               end
        OP_SLL, OP_SRL, OP_SRA: begin
          if (bus.b[SHW-1:0] == '0) begin
            wr    = 1'b1;
            res_w = bus.a;
          end else begin
            op_d    = bus.op;
            lo_d    = bus.a;
            cnt_d   = CW'(bus.b[SHW-1:0]);
            state_d = BUSY;
          end
        end
        OP_MUL: begin
          op_d    = bus.op;
          mcand_d = bus.a;
          lo_d    = bus.b;
          hi_d    = '0;
          cnt_d   = CW'(WIDTH);
          state_d = BUSY;
        end
        default: begin
          wr    = 1'b1;
          res_w = '0;
          err_w = 1'b1;
        end
      endcase
    end else if ((state_q == DONE) && bus.out_ready) begin
      state_d = IDLE;
    end

    if (wr) begin
      result_d = res_w;
      z_d      = ~|res_w;
      n_d      = res_w[WIDTH-1];
      c_d      = c_w;
      v_d      = v_w;
      err_d    = err_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] r;
    logic        fz, fn, fc, fv, fe;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   nchk;
  int   nbad;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: plain wide arithmetic from the op definitions.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    vec_t        e;
    logic [63:0] w;
    longint      s;
    int          n;
    logic [31:0] ci;
    e = '{op, a, b, cin, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    n  = int'(b[4:0]);
    ci = {31'b0, cin};
    case (op)
      4'h0, 4'h2: begin
        if (op == 4'h0) ci = 32'h0;
        w    = {32'h0, a} + {32'h0, b} + {32'h0, ci};
        e.r  = w[31:0];
        e.fc = w[32];
        s    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        e.fv = (s != longint'($signed(e.r)));
      end
      4'h3: begin
        e.r  = a - b;
        e.fc = (a >= b);
        s    = longint'($signed(a)) - longint'($signed(b));
        e.fv = (s != longint'($signed(e.r)));
      end
      4'h4: e.r = a | b;
      4'h5: e.r = ~(a | b);
      4'h6: e.r = a & b;
      4'h7: e.r = 32'h0;
      4'h8: begin e.r = a << n; e.fc = (n != 0) ? a[32-n] : 1'b0; e.lat = n + 1; end
      4'h9: begin e.r = a >> n; e.fc = (n != 0) ? a[n-1]  : 1'b0; e.lat = n + 1; end
      4'hA: begin
        e.r  = $unsigned($signed(a) >>> n);
        e.fc = (n != 0) ? a[n-1] : 1'b0;
        e.lat = n + 1;
      end
      4'hB: begin
        w    = {32'h0, a} * {32'h0, b};
        e.r  = w[31:0];
        e.fc = |w[63:32];
        e.lat = 33;
      end
      default: e.fe = 1'b1;
    endcase
    e.fz = (e.r == 32'h0);
    e.fn = e.r[31];
    return e;
  endfunction

  task automatic scramble();
    bus.op  = 4'($urandom_range(0, 15));
    bus.a   = $urandom;
    bus.b   = $urandom;
    bus.cin = 1'($urandom_range(0, 1));
  endtask

  // Present an op at the current negedge, then wait (bounded) for out_valid.
  // Returns at the negedge where out_valid is first seen, out_ready still 1.
  task automatic issue(input vec_t v, output int lat);
    bus.op        = v.op;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.cin       = v.cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    nchk++;
    if (bus.in_ready !== 1'b1) begin
      nbad++;
      $display("FAIL in_ready_at_issue: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      scramble();
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1)
      $display("FAIL timeout: out_valid not seen within %0d cycles", lat);
    scramble();
  endtask

  task automatic check_out(input string nm, input vec_t e, input int lat);
    logic [4:0] gf;
    logic [4:0] wf;
    gf = {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err};
    wf = {e.fz, e.fn, e.fc, e.fv, e.fe};
    nchk++;
    if (bus.result !== e.r) begin
      nbad++;
      $display("FAIL %s result: got %h want %h", nm, bus.result, e.r);
    end
    nchk++;
    if (gf !== wf) begin
      nbad++;
      $display("FAIL %s flags{z,n,c,v,err}: got %b want %b", nm, gf, wf);
    end
    nchk++;
    if (lat != e.lat || bus.out_valid !== 1'b1) begin
      nbad++;
      $display("FAIL %s latency: got %0d (out_valid=%b) want %0d", nm, lat, bus.out_valid, e.lat);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    issue(v, lat);
    check_out(nm, v, lat);
  endtask

  task automatic expect_bit(input string nm, input logic got, input logic want);
    nchk++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic expect_word(input string nm, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_idle_reset(input string nm);
    expect_bit({nm, "_in_ready"}, bus.in_ready, 1'b1);
    expect_bit({nm, "_out_valid"}, bus.out_valid, 1'b0);
    expect_word({nm, "_result"}, bus.result, 32'h0);
    expect_word({nm, "_flags"},
                {27'h0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err}, 32'h0);
  endtask

  vec_t tbl[18];

  initial begin
    vec_t v;
    int   lat;
    nchk = 0;
    nbad = 0;

    //        op     a             b             cin   r             z     n     c     v     e    lat
    tbl[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[1]  = '{4'h3, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'h2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'hA, 32'h80000010, 32'h00000004, 1'b0, 32'hF8000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    tbl[4]  = '{4'h8, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{4'hB, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 33};
    tbl[6]  = '{4'hB, 32'h00000003, 32'h00000007, 1'b0, 32'h00000015, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33};
    tbl[7]  = '{4'hD, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[8]  = '{4'h4, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'h6, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 32'h000F000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{4'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{4'h1, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[12] = '{4'h3, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[13] = '{4'h3, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[14] = '{4'h9, 32'h00000003, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[15] = '{4'h8, 32'h00000001, 32'h0000001F, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32};
    tbl[16] = '{4'hA, 32'h80000000, 32'h0000001F, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32};
    tbl[17] = '{4'h8, 32'h12345678, 32'h00000020, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 4'h0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.cin       = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_reset("reset_state");

    // Table vectors, issued back-to-back (SUB -> ADDC checks zero-gap throughput).
    for (int i = 0; i < 18; i++)
      run_vec($sformatf("tbl%0d", i), tbl[i]);
    @(negedge clk);

    // Output stall: NOR held for 10 cycles, junk request must not be taken.
    v = '{4'h5, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    issue(v, lat);
    bus.out_ready = 1'b0;
    check_out("nor_stall", v, lat);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      scramble();
      @(negedge clk);
      check_out($sformatf("stall_c%0d", c), v, 1);
      expect_bit($sformatf("stall_in_ready_c%0d", c), bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    expect_bit("after_stall_out_valid", bus.out_valid, 1'b0);

    // Reset on the 10th BUSY cycle of a MUL.
    bus.op       = 4'hB;
    bus.a        = 32'h00001234;
    bus.b        = 32'h00005678;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_bit("mul_busy_in_ready", bus.in_ready, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_reset("mid_mul_reset");
    @(negedge clk);
    expect_bit("mid_mul_reset_stays_idle", bus.out_valid, 1'b0);
    v = model(4'h0, 32'h2, 32'h3, 1'b0);
    run_vec("add_after_reset", v);
    expect_word("add_after_reset_value", bus.result, 32'h5);

    // Randomised ops against the model, with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'h0} | (ra & 32'hF);
      if ($urandom_range(0, 5) == 0) @(negedge clk);
      v = model(rop, ra, rb, 1'($urandom_range(0, 1)));
      run_vec($sformatf("rnd%0d_op%h", i, rop), v);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule
